// File: rtl/chanfpga_pkg.sv
// -----------------------------------------------------------------------------
// chanfpga_pkg
// Shared constants and helpers for the chanfpga channel datapath.
//   COEF_ONE            : unsigned Q1.15 coefficient value representing 1.0
//   PROD_MSB / PROD_LSB : slice of the 36-bit gain product that forms the
//                         16-bit output sample (also used by other gain logic)
//   sext18 / zext18     : widen 16-bit operands to the 18-bit multiplier ports
// -----------------------------------------------------------------------------
package chanfpga_pkg;

    localparam logic [15:0] COEF_ONE = 16'h8000;
    localparam int          PROD_MSB = 28;
    localparam int          PROD_LSB = 13;

    typedef logic signed [15:0] sample_t;
    typedef logic        [15:0] coef_t;

    // Signed sample onto an 18-bit signed multiplier port.
    function automatic logic signed [17:0] sext18(input logic [15:0] v);
        return {{2{v[15]}}, v};
    endfunction

    // Unsigned coefficient onto an 18-bit signed multiplier port.
    function automatic logic signed [17:0] zext18(input logic [15:0] v);
        return {2'b00, v};
    endfunction

endpackage

// File: rtl/normmult_sched_if.sv
// -----------------------------------------------------------------------------
// normmult_sched_if
// Bundle of the requester handshake, coefficient config bus and normalized
// output stream of normmult_sched.
//   master : requester/config side (drives en, req, din, cfg_*)
//   slave  : scheduler side (drives ack, dout, dout_valid, dout_chan)
// -----------------------------------------------------------------------------
interface normmult_sched_if #(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
);
    logic                en;
    logic [NCH-1:0]      req;
    logic [16*NCH-1:0]   din;
    logic [NCH-1:0]      ack;
    logic                cfg_we;
    logic [CW-1:0]       cfg_addr;
    logic [15:0]         cfg_wdata;
    logic [15:0]         dout;
    logic                dout_valid;
    logic [CW-1:0]       dout_chan;

    modport master (
        output en, req, din, cfg_we, cfg_addr, cfg_wdata,
        input  ack, dout, dout_valid, dout_chan
    );

    modport slave (
        input  en, req, din, cfg_we, cfg_addr, cfg_wdata,
        output ack, dout, dout_valid, dout_chan
    );
endinterface

// File: rtl/normmult_stage.sv
// -----------------------------------------------------------------------------
// normmult_stage
// Registered 18x18 signed multiply (one DSP48A1): sample sign-extended,
// coefficient zero-extended, output taken from product[PROD_MSB:PROD_LSB].
// Valid and channel tag are registered alongside the product.
//   clk, rst_n           : clock, asynchronous active-low reset
//   v_in, d_in, c_in,
//   chan_in              : stage A contents (valid, sample, coef, channel)
//   dout, dout_valid,
//   dout_chan            : normalized sample (0 when not valid), qualifier, tag
// -----------------------------------------------------------------------------
module normmult_stage
    import chanfpga_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          v_in,
    input  logic [15:0]   d_in,
    input  logic [15:0]   c_in,
    input  logic [CW-1:0] chan_in,
    output logic [15:0]   dout,
    output logic          dout_valid,
    output logic [CW-1:0] dout_chan
);

    logic signed [17:0] a_ext;
    logic signed [17:0] b_ext;
    logic signed [35:0] prod_reg;
    logic               valid_reg;
    logic [CW-1:0]      chan_reg;

    assign a_ext = sext18(d_in);
    assign b_ext = zext18(c_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg  <= '0;
            valid_reg <= 1'b0;
            chan_reg  <= '0;
        end else begin
            prod_reg  <= a_ext * b_ext;
            valid_reg <= v_in;
            chan_reg  <= chan_in;
        end
    end

    // No saturation: inputs are bounded upstream, out-of-range values wrap.
    assign dout       = valid_reg ? prod_reg[PROD_MSB:PROD_LSB] : 16'h0000;
    assign dout_valid = valid_reg;
    assign dout_chan  = chan_reg;

    // Product bits outside the output slice are intentionally dropped.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{prod_reg[35:PROD_MSB+1], prod_reg[PROD_LSB-1:0]};

endmodule

// File: rtl/normmult_sched.sv
// -----------------------------------------------------------------------------
// normmult_sched
// Round-robin scheduler feeding NCH requesters into one shared normalizing
// multiplier. Holds the per-channel coefficient bank and stage A; stage B
// (multiply + output slice) lives in normmult_stage.
//   clk   : master clock
//   rst_n : asynchronous active-low reset
//   bus   : normmult_sched_if.slave (req/din/ack handshake, en, cfg_* writes,
//           dout/dout_valid/dout_chan output stream)
// Latency: sample acked in cycle N is on dout in cycle N+2.
// -----------------------------------------------------------------------------
module normmult_sched
    import chanfpga_pkg::*;
#(
    parameter int          NCH      = 4,
    parameter int          CW       = $clog2(NCH),
    parameter logic [15:0] COEF_RST = COEF_ONE
) (
    input  logic              clk,
    input  logic              rst_n,
    normmult_sched_if.slave   bus
);

    logic [CW-1:0] ptr_reg;
    logic [15:0]   coef_reg [NCH];
    logic [15:0]   din_ch   [NCH];

    logic          grant_valid;
    logic [CW-1:0] grant_idx;
    logic [CW-1:0] cand;

    logic          v_a_reg;
    logic [15:0]   d_a_reg;
    logic [15:0]   c_a_reg;
    logic [CW-1:0] chan_a_reg;

    // Per-channel sample unpack, one-hot ack and coefficient registers.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign din_ch[gi]  = bus.din[16*gi +: 16];
            assign bus.ack[gi] = grant_valid && (grant_idx == CW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    coef_reg[gi] <= COEF_RST;
                end else if (bus.cfg_we && (bus.cfg_addr == CW'(gi))) begin
                    coef_reg[gi] <= bus.cfg_wdata;
                end
            end
        end
    endgenerate

    // Rotating-priority search. Scanning from the farthest candidate down to
    // ptr and overwriting leaves the first requester at or after ptr. NCH is a
    // power of two, so the CW-bit add wraps modulo NCH for free.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = ptr_reg + CW'(i);
            if (bus.req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        // Requests are ignored while disabled or held in reset.
        if (!bus.en || !rst_n) begin
            grant_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (grant_valid) begin
            ptr_reg <= grant_idx + CW'(1);
        end
    end

    // Stage A. coef_reg is read before a same-edge cfg write lands, so a grant
    // colliding with a write to its own coefficient uses the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_a_reg    <= 1'b0;
            d_a_reg    <= '0;
            c_a_reg    <= '0;
            chan_a_reg <= '0;
        end else begin
            v_a_reg <= grant_valid;
            if (grant_valid) begin
                d_a_reg    <= din_ch[grant_idx];
                c_a_reg    <= coef_reg[grant_idx];
                chan_a_reg <= grant_idx;
            end
        end
    end

    normmult_stage #(
        .CW (CW)
    ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_in       (v_a_reg),
        .d_in       (d_a_reg),
        .c_in       (c_a_reg),
        .chan_in    (chan_a_reg),
        .dout       (bus.dout),
        .dout_valid (bus.dout_valid),
        .dout_chan  (bus.dout_chan)
    );

endmodule

// File: tb/tb_normmult_sched.sv
// -----------------------------------------------------------------------------
// tb_normmult_sched
// Directed bench for normmult_sched (NCH=4). Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_normmult_sched;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    normmult_sched_if #(.NCH(NCH), .CW(CW)) bus ();

    normmult_sched #(
        .NCH      (NCH),
        .CW       (CW),
        .COEF_RST (16'h8000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic set_din(input int ch, input logic [15:0] v);
        bus.din[16*ch +: 16] = v;
    endtask

    task automatic test_reset();
        bus.en        = 1'b1;
        bus.req       = 4'b1111;
        bus.din       = {4{16'h0011}};
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        rst_n         = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
        n_tests++;
        if (bus.dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", bus.dout); end
        n_tests++;
        if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.dout_valid); end
        n_tests++;
        if (bus.dout_chan !== 2'd0) begin n_fail++; $display("FAIL reset_chan: got %0d expected 0", bus.dout_chan); end
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset: done");
    endtask

    // din0=100 with unity coefficient -> 400, two cycles after the ack.
    task automatic test_basic();
        @(negedge clk);
        set_din(0, 16'd100);
        bus.req = 4'b0001;
        #1;
        n_tests++;
        if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL basic_ack: got %b expected 0001", bus.ack); end
        @(negedge clk);
        bus.req = '0;
        #1;
        n_tests++;
        if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", bus.dout_valid); end
        @(negedge clk); #1;
        n_tests++;
        if (bus.dout !== 16'h0190 || bus.dout_valid !== 1'b1 || bus.dout_chan !== 2'd0)
            begin n_fail++; $display("FAIL basic_out: got dout=%h v=%b ch=%0d expected dout=0190 v=1 ch=0", bus.dout, bus.dout_valid, bus.dout_chan); end
        @(negedge clk); #1;
        n_tests++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 16'h0000)
            begin n_fail++; $display("FAIL basic_single_cycle: got dout=%h v=%b expected dout=0000 v=0", bus.dout, bus.dout_valid); end
        $display("[TB] basic: ch0 din=100 -> dout=%h", 16'h0190);
    endtask

    // coef[1]=0x4000 then din1=-100 -> -200; then a collision write of 0x2000.
    task automatic test_coef();
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_wdata = 16'h4000;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        set_din(1, 16'hFF9C);
        bus.req = 4'b0010;
        #1;
        n_tests++;
        if (bus.ack !== 4'b0010) begin n_fail++; $display("FAIL coef_ack: got %b expected 0010", bus.ack); end
        @(negedge clk);
        bus.req = '0;
        @(negedge clk); #1;
        n_tests++;
        if (bus.dout !== 16'hFF38 || bus.dout_valid !== 1'b1 || bus.dout_chan !== 2'd1)
            begin n_fail++; $display("FAIL coef_half: got dout=%h v=%b ch=%0d expected dout=ff38 v=1 ch=1", bus.dout, bus.dout_valid, bus.dout_chan); end
        $display("[TB] coef: ch1 coef=4000 din=-100 -> dout=ff38");

        @(negedge clk);
        bus.req = 4'b0010;
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_wdata = 16'h2000;
        #1;
        n_tests++;
        if (bus.ack !== 4'b0010) begin n_fail++; $display("FAIL collide_ack0: got %b expected 0010", bus.ack); end
        @(negedge clk);
        bus.cfg_we = 1'b0;
        #1;
        n_tests++;
        if (bus.ack !== 4'b0010) begin n_fail++; $display("FAIL collide_ack1: got %b expected 0010", bus.ack); end
        @(negedge clk);
        bus.req = '0;
        #1;
        n_tests++;
        if (bus.dout !== 16'hFF38 || bus.dout_chan !== 2'd1)
            begin n_fail++; $display("FAIL collide_old_coef: got dout=%h ch=%0d expected dout=ff38 ch=1", bus.dout, bus.dout_chan); end
        @(negedge clk); #1;
        n_tests++;
        if (bus.dout !== 16'hFF9C || bus.dout_valid !== 1'b1 || bus.dout_chan !== 2'd1)
            begin n_fail++; $display("FAIL collide_new_coef: got dout=%h v=%b ch=%0d expected dout=ff9c v=1 ch=1", bus.dout, bus.dout_valid, bus.dout_chan); end
        $display("[TB] collision: ch1 old coef -> ff38, next -> ff9c");
    endtask

    // Fresh reset, all four requesting: 0,1,2,3,0,1,2,3 with din_i=10*(i+1).
    task automatic test_round_robin();
        logic [3:0]  exp_ack;
        logic [1:0]  exp_chan;
        logic [15:0] exp_dout;
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) set_din(i, 16'(10 * (i + 1)));
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            bus.req = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_ack = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
            n_tests++;
            if (bus.ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", k, bus.ack, exp_ack); end
            if (k >= 2 && k < 10) begin
                exp_chan = 2'((k - 2) % 4);
                exp_dout = 16'(40 * (((k - 2) % 4) + 1));
                n_tests++;
                if (bus.dout_valid !== 1'b1 || bus.dout_chan !== exp_chan || bus.dout !== exp_dout)
                    begin n_fail++; $display("FAIL rr_out[%0d]: got dout=%0d v=%b ch=%0d expected dout=%0d v=1 ch=%0d", k, bus.dout, bus.dout_valid, bus.dout_chan, exp_dout, exp_chan); end
            end else begin
                n_tests++;
                if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle[%0d]: got v=%b expected 0", k, bus.dout_valid); end
            end
            $display("[TB] rr cycle %0d: ack=%b dout=%0d v=%b ch=%0d", k, bus.ack, bus.dout, bus.dout_valid, bus.dout_chan);
        end
    endtask

    // Walk ptr to 2, then req=1011 -> 3,0,1,3 with no bubble.
    task automatic test_skip();
        logic [3:0] exp_seq  [4];
        logic [1:0] exp_chan [4];
        exp_seq  = '{4'b1000, 4'b0001, 4'b0010, 4'b1000};
        exp_chan = '{2'd0, 2'd1, 2'd3, 2'd0};
        @(negedge clk);
        bus.req = 4'b0011;
        #1;
        n_tests++;
        if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL skip_pre0: got %b expected 0001", bus.ack); end
        @(negedge clk); #1;
        n_tests++;
        if (bus.ack !== 4'b0010) begin n_fail++; $display("FAIL skip_pre1: got %b expected 0010", bus.ack); end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            bus.req = 4'b1011;
            #1;
            n_tests++;
            if (bus.ack !== exp_seq[j]) begin n_fail++; $display("FAIL skip_ack[%0d]: got %b expected %b", j, bus.ack, exp_seq[j]); end
            n_tests++;
            if (bus.dout_valid !== 1'b1 || bus.dout_chan !== exp_chan[j])
                begin n_fail++; $display("FAIL skip_out[%0d]: got v=%b ch=%0d expected v=1 ch=%0d", j, bus.dout_valid, bus.dout_chan, exp_chan[j]); end
            $display("[TB] skip %0d: ack=%b out_ch=%0d", j, bus.ack, bus.dout_chan);
        end
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // ptr=0: grant 0,1, then en low for 3 cycles, then resume at ch2.
    task automatic test_en();
        logic [3:0]  exp_ack  [6];
        logic        exp_v    [6];
        logic [15:0] exp_dout [6];
        exp_ack  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        exp_v    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_dout = '{16'd0, 16'd0, 16'd40, 16'd80, 16'd0, 16'd0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.req = 4'b1111;
            bus.en  = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            #1;
            n_tests++;
            if (bus.ack !== exp_ack[c]) begin n_fail++; $display("FAIL en_ack[%0d]: got %b expected %b", c, bus.ack, exp_ack[c]); end
            n_tests++;
            if (bus.dout_valid !== exp_v[c] || bus.dout !== exp_dout[c])
                begin n_fail++; $display("FAIL en_out[%0d]: got dout=%0d v=%b expected dout=%0d v=%b", c, bus.dout, bus.dout_valid, exp_dout[c], exp_v[c]); end
            $display("[TB] en cycle %0d: en=%b ack=%b dout=%0d v=%b", c, bus.en, bus.ack, bus.dout, bus.dout_valid);
        end
        @(negedge clk);
        bus.en  = 1'b1;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Async reset mid-cycle with A/B full; coef[0] must return to 0x8000.
    task automatic test_async_reset();
        @(negedge clk);
        bus.req = 4'b1111;
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = 16'h1000;
        #1;
        n_tests++;
        if (bus.ack !== 4'b1000) begin n_fail++; $display("FAIL areset_pre_ack: got %b expected 1000", bus.ack); end
        @(negedge clk);
        bus.cfg_we = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL areset_full: got v=%b expected 1", bus.dout_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 16'h0000 || bus.dout_chan !== 2'd0 || bus.ack !== 4'b0000)
            begin n_fail++; $display("FAIL areset_now: got dout=%h v=%b ch=%0d ack=%b expected 0000/0/0/0000", bus.dout, bus.dout_valid, bus.dout_chan, bus.ack); end
        @(negedge clk);
        rst_n = 1'b1;
        set_din(0, 16'd100);
        bus.req = 4'b0001;
        #1;
        n_tests++;
        if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL areset_first_grant: got %b expected 0001", bus.ack); end
        @(negedge clk);
        bus.req = '0;
        @(negedge clk); #1;
        n_tests++;
        if (bus.dout !== 16'h0190 || bus.dout_valid !== 1'b1)
            begin n_fail++; $display("FAIL areset_coef: got dout=%h v=%b expected dout=0190 v=1", bus.dout, bus.dout_valid); end
        $display("[TB] async reset: outputs cleared, ch0 -> %h", bus.dout);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coef();
        test_round_robin();
        test_skip();
        test_en();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/normmult_sched.md
# normmult_sched

Time-shared scheduler for the channel normalizing multiplier: accepts samples from NCH requesters, arbitrates them round-robin onto one 18x18 signed multiply stage, and applies a per-channel 16-bit normalizing coefficient held in a local register bank. It sits between the per-channel baseline/ADC stages and the trigger/readout logic in chanfpga. Its output is one normalized sample per cycle, tagged with its source channel.

## Interface
Parameters:
- NCH, 4, number of requesters (power of 2, 2..16)
- CW, $clog2(NCH), channel index width
- COEF_RST, 16'h8000, coefficient reset value (1.0)

Ports:
- clk  in  1  master clock, 125 MHz
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scheduler enable; when low, no new grants are issued
- req  in  NCH  per-channel request, held until acked
- din  in  16*NCH  per-channel signed sample, channel i at [16*i+15:16*i], stable while req[i] is high
- ack  out  NCH  combinational one-hot grant; sample is taken on the clock edge where ack[i]=1
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  CW  coefficient index
- cfg_wdata  in  16  unsigned coefficient, 1.0 = 0x8000
- dout  out  16  normalized signed sample
- dout_valid  out  1  dout qualifier, single-cycle per sample
- dout_chan  out  CW  source channel of dout

## Operation
- Arbiter: rotating pointer ptr, reset 0. Grant goes to the first i with req[i]=1, searching ptr, ptr+1, … mod NCH. At most one ack bit is high per cycle. ack=0 when en=0 or req=0.
- On a grant edge, ptr <= granted index + 1 mod NCH. With no grant, ptr holds.
- Stage A, on the grant edge: registers din of the granted channel, coef[granted], chan, vA=1. Otherwise vA <= 0.
- Stage B: product <= sext18(dA) * zext18(cA), 36-bit signed. dout = product[28:13], so unity gain gives 4×din. There is no saturation. din is guaranteed to be within ±4095 upstream; values outside that range wrap.
- dout_valid and dout_chan are registered alongside product. dout is forced to 0 when dout_valid=0.
- Coefficient bank: NCH×16 registers, reset to COEF_RST. A write with cfg_we=1 takes effect on that edge.
- Write collision: if a grant for channel k and a write to coef[k] occur in the same cycle, stage A captures the old coefficient. The new value applies from the next grant.
- en falling: samples already in stages A/B complete normally. No new acks are issued.
- Reset mid-operation: all in-flight samples are discarded. No ack is lost silently, because the requester sees ack only on an edge where the sample was sampled.

## Timing
- Reset values: ack=0 (req is ignored during reset), dout=0, dout_valid=0, dout_chan=0, ptr=0, all coef=COEF_RST, vA=0.
- Latency: a sample acked at edge N appears on dout with dout_valid=1 after edge N+2, i.e. visible in cycle N+2.
- Throughput: one sample per cycle. With all req high, each channel is served once every NCH cycles.
- Requester handshake: the requester may drop req or present a new sample in the cycle after the ack edge.
- ack is combinational from req, en and ptr. req must be glitch-free, i.e. registered, at the requester.

## Structure
- Shared package chanfpga_pkg:
  - COEF_ONE = 16'h8000.
  - Product slice constants PROD_MSB=28 and PROD_LSB=13, also used by other gain logic.
- Sub-module normmult_stage: stage B (sign/zero extension, 18x18 registered multiply with async reset, output slice, valid/chan passthrough). It maps to one DSP48A1.
- Arbiter, pointer, coefficient bank and stage A remain in the top level.

## Test plan
- Reset, then din0=100 and req0 held for one grant with default coef → ack0 at cycle 0; dout=400 (16'h0190), dout_valid=1, dout_chan=0 two cycles later.
- Write coef[1]=0x4000, then din1=-100 → dout=16'hFF38 (-200), dout_chan=1. Same-cycle write of coef[1]=0x2000 with grant of ch1 → that sample is still scaled by 0x4000, and the next ch1 sample by 0x2000.
- All four req held high continuously for 8 cycles → ack sequence 0,1,2,3,0,1,2,3. dout_valid is high every cycle from cycle 2, with dout_chan following the same order.
- ptr=2, req=4'b1011 → grant order 3,0,1, then 3. ch2 is skipped with no bubble.
- en dropped for 3 cycles with all req high → ack=0 for those 3 cycles. The two in-flight samples still emerge. Afterwards, granting resumes from the stored ptr.
- rst_n asserted asynchronously while stages A/B are full → dout_valid=0 and dout=0 immediately, coef bank returns to 0x8000, and the first grant after release goes to ch0.
